// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide
// sharing one 2*XLEN register, with a final sign-fix edge and a fast path for div corner cases.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             Clk_i,
  input  logic             Rstn_i,
  input  logic             Valid_i,
  output logic             Ready_o,
  input  logic [2:0]       Op_i,
  input  logic [XLEN-1:0]  OperandA_i,
  input  logic [XLEN-1:0]  OperandB_i,
  input  logic [TAG_W-1:0] Tag_i,
  input  logic             Flush_i,
  output logic             Valid_o,
  input  logic             Ready_i,
  output logic [XLEN-1:0]  Result_o,
  output logic [TAG_W-1:0] Tag_o
);

  localparam int W2    = 2 * XLEN;
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0]  ONE_X    = XLEN'(1);
  localparam logic [W2-1:0]    ONE_2X   = W2'(1);
  localparam logic [XLEN-1:0]  MIN_X    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [W2-1:0] negate(input logic [W2-1:0] v);
    return ~v + ONE_2X;
  endfunction

  state_e           r_state, w_next;
  op_e              r_op;
  logic             r_neg;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_m;
  logic [W2-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_tag_out;

  op_e              w_op;
  logic             w_accept, w_sa, w_sb, w_b_zero, w_ovf, w_special, w_neg;
  logic             w_iter, w_fix;
  logic [XLEN-1:0]  w_mag_a, w_mag_b, w_spec_res, w_addend;
  logic [XLEN:0]    w_add, w_rem_sh, w_diff;
  logic [W2-1:0]    w_acc_next, w_sel, w_fixed;
  logic [XLEN-1:0]  w_res;

  // Request decode: operand magnitudes, sign flags and divide corner cases
  assign w_op       = op_e'(Op_i);
  assign w_accept   = Valid_i && (r_state == ST_IDLE) && !Flush_i;
  assign w_sa       = is_signed_a(w_op) && OperandA_i[XLEN-1];
  assign w_sb       = is_signed_b(w_op) && OperandB_i[XLEN-1];
  assign w_mag_a    = w_sa ? (~OperandA_i + ONE_X) : OperandA_i;
  assign w_mag_b    = w_sb ? (~OperandB_i + ONE_X) : OperandB_i;
  assign w_b_zero   = (OperandB_i == '0);
  assign w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                      (OperandA_i == MIN_X) && (OperandB_i == '1);
  assign w_special  = is_div(w_op) && (w_b_zero || w_ovf);
  assign w_spec_res = w_b_zero ? (w_op[1] ? OperandA_i : '1)
                               : (w_op[1] ? '0 : OperandA_i);
  // Remainder follows the dividend sign; quotient and products follow sign xor
  assign w_neg      = (is_div(w_op) && w_op[1]) ? w_sa : (w_sa ^ w_sb);

  // Iteration datapath: shift-add for multiply, trial subtract for divide
  assign w_iter     = (r_state == ST_BUSY) && (r_cnt != '0);
  assign w_fix      = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_addend   = r_acc[0] ? r_m : '0;
  assign w_add      = {1'b0, r_acc[W2-1:XLEN]} + {1'b0, w_addend};
  assign w_rem_sh   = r_acc[W2-1:XLEN-1];
  assign w_diff     = w_rem_sh - {1'b0, r_m};
  assign w_acc_next = is_div(r_op)
                      ? (w_diff[XLEN] ? {r_acc[W2-2:0], 1'b0}
                                      : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1})
                      : {w_add, r_acc[XLEN-1:1]};

  // Sign-fix stage: pick quotient, remainder or product, then conditionally negate
  assign w_sel      = !is_div(r_op) ? r_acc
                    : (r_op[1] ? {{XLEN{1'b0}}, r_acc[W2-1:XLEN]}
                               : {{XLEN{1'b0}}, r_acc[XLEN-1:0]});
  assign w_fixed    = r_neg ? negate(w_sel) : w_sel;
  assign w_res      = ((r_op == OP_MUL) || is_div(r_op)) ? w_fixed[XLEN-1:0]
                                                         : w_fixed[W2-1:XLEN];

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_special ? ST_DONE : ST_BUSY;
      ST_BUSY: if (w_fix)    w_next = ST_DONE;
      ST_DONE: if (Ready_i)  w_next = ST_IDLE;
      default:               w_next = ST_IDLE;
    endcase
    if (Flush_i) w_next = ST_IDLE;
  end

  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_result  <= '0;
      r_tag_out <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && !w_special) r_cnt <= CNT_LOAD;
      else if (w_iter)            r_cnt <= r_cnt - CNT_ONE;
      if (w_accept && w_special) begin
        r_result  <= w_spec_res;
        r_tag_out <= Tag_i;
      end else if (w_fix && !Flush_i) begin
        r_result  <= w_res;
        r_tag_out <= r_tag;
      end
    end
  end

  always_ff @(posedge Clk_i) begin
    if (w_accept) begin
      r_op  <= w_op;
      r_neg <= w_neg;
      r_tag <= Tag_i;
      r_m   <= is_div(w_op) ? w_mag_b : w_mag_a;
      r_acc <= {{XLEN{1'b0}}, (is_div(w_op) ? w_mag_a : w_mag_b)};
    end else if (w_iter) begin
      r_acc <= w_acc_next;
    end
  end

  assign Ready_o  = (r_state == ST_IDLE);
  assign Valid_o  = (r_state == ST_DONE);
  assign Result_o = r_result;
  assign Tag_o    = r_tag_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32: arithmetic vectors, latency, hold, flush and reset.
module tb_muldiv_unit;

  logic        Clk_i = 1'b0;
  logic        Rstn_i = 1'b0;
  logic        Valid_i = 1'b0;
  logic        Ready_o;
  logic [2:0]  Op_i = '0;
  logic [31:0] OperandA_i = '0;
  logic [31:0] OperandB_i = '0;
  logic [4:0]  Tag_i = '0;
  logic        Flush_i = 1'b0;
  logic        Valid_o;
  logic        Ready_i = 1'b0;
  logic [31:0] Result_o;
  logic [4:0]  Tag_o;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .Clk_i      (Clk_i),
    .Rstn_i     (Rstn_i),
    .Valid_i    (Valid_i),
    .Ready_o    (Ready_o),
    .Op_i       (Op_i),
    .OperandA_i (OperandA_i),
    .OperandB_i (OperandB_i),
    .Tag_i      (Tag_i),
    .Flush_i    (Flush_i),
    .Valid_o    (Valid_o),
    .Ready_i    (Ready_i),
    .Result_o   (Result_o),
    .Tag_o      (Tag_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Issue one request, wait (bounded) for the result, capture it and consume it.
  // lat counts edges after the accepting edge until Valid_o is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res,
                        output logic [4:0] tg, output int lat);
    Valid_i = 1'b1; Op_i = op; OperandA_i = a; OperandB_i = b; Tag_i = tag;
    @(posedge Clk_i); #1;
    Valid_i = 1'b0;
    lat = 0;
    while (!Valid_o && lat < 60) begin
      @(posedge Clk_i); #1;
      lat++;
    end
    res = Result_o;
    tg  = Tag_o;
    Ready_i = 1'b1;
    @(posedge Clk_i); #1;
    Ready_i = 1'b0;
  endtask

  task automatic test_reset();
    Rstn_i = 1'b0;
    repeat (3) @(posedge Clk_i);
    #1;
    n_tests++; if (Ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", Ready_o); end
    n_tests++; if (Valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", Valid_o); end
    n_tests++; if (Result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", Result_o); end
    n_tests++; if (Tag_o !== 5'h0) begin n_fail++; $display("FAIL reset_tag got %h want 0", Tag_o); end
    Rstn_i = 1'b1;
    @(posedge Clk_i); #1;
  endtask

  task automatic test_mul();
    logic [31:0] res; logic [4:0] tg; int lat;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, res, tg, lat);
    n_tests++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_res got %h want ffffffeb", res); end
    n_tests++; if (tg !== 5'd3) begin n_fail++; $display("FAIL mul_tag got %0d want 3", tg); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency got %0d want 33", lat); end
    run_op(3'b001, 32'h80000000, 32'h80000000, 5'd4, res, tg, lat);
    n_tests++; if (res !== 32'h40000000) begin n_fail++; $display("FAIL mulh_res got %h want 40000000", res); end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, res, tg, lat);
    n_tests++; if (res !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_res got %h want fffffffe", res); end
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, res, tg, lat);
    n_tests++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu_res got %h want ffffffff", res); end
    n_tests++; if (tg !== 5'd6) begin n_fail++; $display("FAIL mulhsu_tag got %0d want 6", tg); end
  endtask

  task automatic test_div();
    logic [31:0] res; logic [4:0] tg; int lat;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd7, res, tg, lat);
    n_tests++; if (res !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_res got %h want fffffffd", res); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency got %0d want 33", lat); end
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd8, res, tg, lat);
    n_tests++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem_res got %h want ffffffff", res); end
    run_op(3'b101, 32'd7, 32'd2, 5'd9, res, tg, lat);
    n_tests++; if (res !== 32'd3) begin n_fail++; $display("FAIL divu_res got %h want 3", res); end
    run_op(3'b111, 32'd7, 32'd2, 5'd10, res, tg, lat);
    n_tests++; if (res !== 32'd1) begin n_fail++; $display("FAIL remu_res got %h want 1", res); end
    n_tests++; if (tg !== 5'd10) begin n_fail++; $display("FAIL remu_tag got %0d want 10", tg); end
  endtask

  // Fast-path results are valid right after the accepting edge.
  task automatic test_special();
    logic [31:0] res; logic [4:0] tg; int lat;
    run_op(3'b100, 32'd5, 32'd0, 5'd11, res, tg, lat);
    n_tests++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_res got %h want ffffffff", res); end
    n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL div0_latency got %0d want 0", lat); end
    n_tests++; if (tg !== 5'd11) begin n_fail++; $display("FAIL div0_tag got %0d want 11", tg); end
    run_op(3'b110, 32'd5, 32'd0, 5'd12, res, tg, lat);
    n_tests++; if (res !== 32'd5) begin n_fail++; $display("FAIL rem0_res got %h want 5", res); end
    n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL rem0_latency got %0d want 0", lat); end
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, res, tg, lat);
    n_tests++; if (res !== 32'h80000000) begin n_fail++; $display("FAIL divovf_res got %h want 80000000", res); end
    n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL divovf_latency got %0d want 0", lat); end
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, res, tg, lat);
    n_tests++; if (res !== 32'h0) begin n_fail++; $display("FAIL removf_res got %h want 0", res); end
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    logic [31:0] res; logic [4:0] tg; int lat2;
    Valid_i = 1'b1; Op_i = 3'b101; OperandA_i = 32'd7; OperandB_i = 32'd2; Tag_i = 5'd9;
    @(posedge Clk_i); #1;
    Valid_i = 1'b0;
    lat = 0;
    while (!Valid_o && lat < 60) begin @(posedge Clk_i); #1; lat++; end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL hold_latency got %0d want 33", lat); end
    // A new request is presented and held while the result waits to be consumed
    Valid_i = 1'b1; Op_i = 3'b000; OperandA_i = 32'd3; OperandB_i = 32'd4; Tag_i = 5'd1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk_i); #1;
      if (Result_o !== 32'd3 || Tag_o !== 5'd9 || Ready_o !== 1'b0 || Valid_o !== 1'b1) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable got %0d bad cycles want 0 (res %h tag %0d)", bad, Result_o, Tag_o); end
    Ready_i = 1'b1;
    @(posedge Clk_i); #1;
    Ready_i = 1'b0;
    n_tests++; if (Ready_o !== 1'b1 || Valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_release got rdy %b vld %b want 1 0", Ready_o, Valid_o); end
    @(posedge Clk_i); #1;
    Valid_i = 1'b0;
    n_tests++; if (Ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_next_accept got ready %b want 0", Ready_o); end
    lat2 = 0;
    while (!Valid_o && lat2 < 60) begin @(posedge Clk_i); #1; lat2++; end
    res = Result_o; tg = Tag_o;
    n_tests++; if (res !== 32'd12 || tg !== 5'd1) begin n_fail++; $display("FAIL hold_next_res got %h/%0d want c/1", res, tg); end
    Ready_i = 1'b1;
    @(posedge Clk_i); #1;
    Ready_i = 1'b0;
  endtask

  task automatic test_flush();
    int seen;
    // Flush together with a request in IDLE: nothing is accepted
    Valid_i = 1'b1; Flush_i = 1'b1; Op_i = 3'b100; OperandA_i = 32'd100; OperandB_i = 32'd7; Tag_i = 5'd5;
    @(posedge Clk_i); #1;
    Flush_i = 1'b0; Valid_i = 1'b0;
    n_tests++; if (Ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_idle got ready %b want 1", Ready_o); end
    // Flush mid-divide
    Valid_i = 1'b1;
    @(posedge Clk_i); #1;
    Valid_i = 1'b0;
    repeat (10) @(posedge Clk_i);
    #1;
    Flush_i = 1'b1;
    @(posedge Clk_i); #1;
    Flush_i = 1'b0;
    n_tests++; if (Ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_busy_ready got %b want 1", Ready_o); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk_i); #1;
      if (Valid_o) seen++;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_valid got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] tg; int lat;
    Valid_i = 1'b1; Op_i = 3'b000; OperandA_i = 32'd9; OperandB_i = 32'd9; Tag_i = 5'd17;
    @(posedge Clk_i); #1;
    Valid_i = 1'b0;
    repeat (5) @(posedge Clk_i);
    #2;
    Rstn_i = 1'b0;
    #1;
    n_tests++; if (Ready_o !== 1'b1 || Valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_hs got rdy %b vld %b want 1 0", Ready_o, Valid_o); end
    n_tests++; if (Result_o !== 32'h0 || Tag_o !== 5'h0) begin n_fail++; $display("FAIL rstmid_out got %h/%0d want 0/0", Result_o, Tag_o); end
    @(posedge Clk_i); #1;
    Rstn_i = 1'b1;
    @(posedge Clk_i); #1;
    run_op(3'b101, 32'd100, 32'd7, 5'd2, res, tg, lat);
    n_tests++; if (res !== 32'd14 || tg !== 5'd2) begin n_fail++; $display("FAIL rstmid_after got %h/%0d want e/2", res, tg); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_hold();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
